// File: rtl/branch_resolver.sv
// Branch resolution unit: queues IF-stage predictions, checks them in program order
// against EX outcomes, drives predictor updates, fetch redirects and statistics.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_push,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_taken,
  input  logic             if_pred_valid,
  input  logic [31:0]      if_pred_target,
  output logic             if_full,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_fallthrough,
  input  logic             flush_i,
  output logic             update_en,
  output logic [31:0]      update_pc,
  output logic             update_taken,
  output logic [31:0]      update_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             q_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic              pred_redirect_q [DEPTH];
  logic [31:0]       pred_target_q   [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;

  logic              empty_p0;
  logic              pop_p0;
  logic              push_p0;
  logic              clear_p0;
  logic              mispredict_p0;
  logic              upd_p0;
  logic              qerr_set_p0;
  logic              head_redirect_p0;
  logic [31:0]       head_target_p0;
  logic [31:0]       actual_next_p0;

  // Resolution follows queue order, so the fetched PC itself is never needed.
  logic unused_pc;
  assign unused_pc = ^if_pc;

  assign if_full = (count == FULL_CNT);

  // Stage p0: combinational resolution of the queue head against EX
  always_comb begin
    empty_p0         = (count == '0);
    head_redirect_p0 = pred_redirect_q[head];
    head_target_p0   = pred_target_q[head];
    actual_next_p0   = (ex_is_branch && ex_taken) ? ex_target : ex_fallthrough;
    pop_p0           = ex_valid && !empty_p0 && !flush_i;
    mispredict_p0    = pop_p0 &&
                       ((head_redirect_p0 && (head_target_p0 != actual_next_p0)) ||
                        (!head_redirect_p0 && (actual_next_p0 != ex_fallthrough)));
    upd_p0           = pop_p0 && ex_is_branch;
    clear_p0         = flush_i || mispredict_p0;
    push_p0          = if_push && !clear_p0 && (!if_full || pop_p0);
    qerr_set_p0      = ex_valid && empty_p0 && !flush_i;
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      pred_redirect_q[tail] <= if_pred_valid && if_pred_taken;
      pred_target_q[tail]   <= if_pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear_p0) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop_p0)  head <= head + PTR_W'(1);
      if (push_p0) tail <= tail + PTR_W'(1);
      case ({push_p0, pop_p0})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p1: registered update/redirect strobes and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_en        <= 1'b0;
      update_pc        <= '0;
      update_taken     <= 1'b0;
      update_target    <= '0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      q_err            <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      update_en      <= upd_p0;
      redirect_valid <= mispredict_p0;
      if (upd_p0) begin
        update_pc     <= ex_pc;
        update_taken  <= ex_taken;
        update_target <= ex_target;
        branch_count  <= sat_inc(branch_count);
      end
      if (mispredict_p0) begin
        redirect_pc      <= actual_next_p0;
        mispredict_count <= sat_inc(mispredict_count);
      end
      if (qerr_set_p0) q_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized bench for branch_resolver against a queue-based prediction model.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic if_push, if_pred_taken, if_pred_valid, if_full;
  logic [31:0] if_pc, if_pred_target;
  logic ex_valid, ex_is_branch, ex_taken, flush_i;
  logic [31:0] ex_pc, ex_target, ex_fallthrough;
  logic update_en, update_taken, redirect_valid, q_err;
  logic [31:0] update_pc, update_target, redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_push(if_push), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_valid(if_pred_valid), .if_pred_target(if_pred_target), .if_full(if_full),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_fallthrough(ex_fallthrough), .flush_i(flush_i),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .q_err(q_err), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
  } ent_t;

  ent_t             mq[$];
  logic             e_uen, e_utk, e_red, e_qerr;
  logic [31:0]      e_upc, e_utg, e_rpc;
  logic [CNT_W-1:0] e_bc, e_mc;
  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    e_uen = 0; e_utk = 0; e_red = 0; e_qerr = 0;
    e_upc = 0; e_utg = 0; e_rpc = 0; e_bc = 0; e_mc = 0;
  endtask

  task automatic idle();
    if_push = 0; if_pc = 0; if_pred_taken = 0; if_pred_valid = 0; if_pred_target = 0;
    ex_valid = 0; ex_pc = 0; ex_is_branch = 0; ex_taken = 0; ex_target = 0;
    ex_fallthrough = 0; flush_i = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".update_en"}, update_en, e_uen);
    chk({tag, ".update_pc"}, update_pc, e_upc);
    chk({tag, ".update_taken"}, update_taken, e_utk);
    chk({tag, ".update_target"}, update_target, e_utg);
    chk({tag, ".redirect_valid"}, redirect_valid, e_red);
    chk({tag, ".redirect_pc"}, redirect_pc, e_rpc);
    chk({tag, ".q_err"}, q_err, e_qerr);
    chk({tag, ".branch_count"}, branch_count, e_bc);
    chk({tag, ".mispredict_count"}, mispredict_count, e_mc);
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic step(input string tag);
    logic ok, mis;
    logic [31:0] act, pred_next;
    int sz;
    ent_t e;
    sz = mq.size();
    chk({tag, ".if_full"}, if_full, (sz == DEPTH));
    ok = ex_valid && !flush_i && (sz > 0);
    act = (ex_is_branch && ex_taken) ? ex_target : ex_fallthrough;
    mis = 0;
    if (ok) begin
      pred_next = mq[0].redir ? mq[0].tgt : ex_fallthrough;
      mis = (pred_next != act);
    end
    e_uen = ok && ex_is_branch;
    if (e_uen) begin
      e_upc = ex_pc; e_utk = ex_taken; e_utg = ex_target;
      if (e_bc != '1) e_bc = e_bc + 1;
    end
    e_red = mis;
    if (mis) begin
      e_rpc = act;
      if (e_mc != '1) e_mc = e_mc + 1;
    end
    if (ex_valid && !flush_i && sz == 0) e_qerr = 1;
    if (flush_i || mis) mq.delete();
    else begin
      if (ok) void'(mq.pop_front());
      if (if_push && (sz < DEPTH || ok)) begin
        e.redir = if_pred_valid && if_pred_taken;
        e.tgt = if_pred_target;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    if_push = 1'($urandom); if_pc = $urandom; ex_valid = 1'($urandom);
    ex_is_branch = 1'($urandom); ex_taken = 1'($urandom); flush_i = 1'($urandom);
    ex_target = $urandom; ex_fallthrough = $urandom; if_pred_target = $urandom;
    rst_n = 0;
    #1;
    model_clear();
    check_outputs({tag, ".async"});
    chk({tag, ".if_full"}, if_full, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    @(negedge clk);
    idle();
    rst_n = 1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic vl, input logic [31:0] tg);
    if_push = 1; if_pc = pc; if_pred_taken = tk; if_pred_valid = vl; if_pred_target = tg;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tg, input logic [31:0] ft);
    ex_valid = 1; ex_pc = pc; ex_is_branch = br; ex_taken = tk; ex_target = tg; ex_fallthrough = ft;
  endtask

  initial begin
    idle();
    rst_n = 1;
    @(negedge clk);
    do_reset("reset0");

    // Not-taken prediction, branch actually taken
    idle(); push(32'h100, 0, 0, 0); step("t1.push");
    idle(); resolve(32'h100, 1, 1, 32'h200, 32'h104); step("t1.res");
    chk("t1.update_pc", update_pc, 32'h100);
    chk("t1.redirect_pc", redirect_pc, 32'h200);
    chk("t1.redirect_valid", redirect_valid, 1);
    chk("t1.mis_cnt", mispredict_count, 1);
    chk("t1.br_cnt", branch_count, 1);
    idle(); step("t1.idle");
    chk("t1.strobe_drop", update_en, 0);

    // Correct taken prediction
    idle(); push(32'h100, 1, 1, 32'h200); step("t2.push");
    idle(); resolve(32'h100, 1, 1, 32'h200, 32'h104); step("t2.res");
    chk("t2.update_en", update_en, 1);
    chk("t2.redirect_valid", redirect_valid, 0);
    chk("t2.mis_cnt", mispredict_count, 1);

    // BTB alias on a non-branch
    idle(); push(32'h300, 1, 1, 32'h400); step("t3.push");
    idle(); resolve(32'h300, 0, 0, 32'h0, 32'h302); step("t3.res");
    chk("t3.redirect_pc", redirect_pc, 32'h302);
    chk("t3.update_en", update_en, 0);
    chk("t3.mis_cnt", mispredict_count, 2);

    // Fill, overflow, push+pop while full, in-order resolution
    idle(); push(32'h10, 0, 0, 0);        step("t4.p0");
    idle(); push(32'h14, 1, 1, 32'h80);   step("t4.p1");
    idle(); push(32'h18, 0, 1, 32'h70);   step("t4.p2");
    idle(); push(32'h1c, 1, 1, 32'h90);   step("t4.p3");
    chk("t4.full", if_full, 1);
    idle(); push(32'h20, 1, 1, 32'hf0);   step("t4.over");
    chk("t4.full_after_over", if_full, 1);
    idle(); push(32'h20, 0, 0, 0); resolve(32'h10, 1, 0, 32'h50, 32'h14); step("t4.pp");
    chk("t4.full_pp", if_full, 1);
    idle(); resolve(32'h14, 1, 1, 32'h80, 32'h18); step("t4.r1");
    chk("t4.r1_red", redirect_valid, 0);
    idle(); resolve(32'h18, 1, 0, 32'h70, 32'h1c); step("t4.r2");
    idle(); resolve(32'h1c, 1, 1, 32'h90, 32'h20); step("t4.r3");
    idle(); resolve(32'h20, 0, 0, 32'h0, 32'h24); step("t4.r4");
    chk("t4.r4_red", redirect_valid, 0);
    chk("t4.mis_cnt", mispredict_count, 2);

    // Mispredict with younger entries and a concurrent push empties the queue
    idle(); push(32'h40, 0, 0, 0); step("t5.p0");
    idle(); push(32'h44, 0, 0, 0); step("t5.p1");
    idle(); push(32'h48, 0, 0, 0); step("t5.p2");
    idle(); push(32'h4c, 0, 0, 0); step("t5.p3");
    idle(); push(32'h50, 0, 0, 0); resolve(32'h40, 1, 1, 32'h600, 32'h44); step("t5.mis");
    chk("t5.redirect_pc", redirect_pc, 32'h600);
    idle(); resolve(32'h604, 1, 0, 32'h0, 32'h608); step("t5.empty");
    chk("t5.q_err", q_err, 1);
    chk("t5.no_update", update_en, 0);
    idle(); step("t5.idle0"); step("t5.idle1");
    chk("t5.q_err_sticky", q_err, 1);

    // Flush with concurrent ex_valid
    idle(); push(32'h700, 0, 0, 0); step("t6.push");
    idle(); resolve(32'h700, 1, 1, 32'h800, 32'h704); flush_i = 1; step("t6.flush");
    chk("t6.update_en", update_en, 0);
    chk("t6.redirect", redirect_valid, 0);

    do_reset("reset1");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset("reset_mid");
      idle();
      if ($urandom_range(0, 1) == 1) begin
        push(32'h100 + 32'($urandom_range(0, 7)) * 4, 1'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h400);
      end
      if ($urandom_range(0, 2) != 0) begin
        resolve(32'h100 + 32'($urandom_range(0, 7)) * 4, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h400,
                ($urandom_range(0, 1) == 1) ? 32'h104 : 32'h102);
      end
      flush_i = ($urandom_range(0, 15) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
